// File: rtl/pipe_ctrl_decode.sv
// Multi-lane main-control decoder for the superscalar MIPS core.
// Decodes LANES opcodes per cycle in ID and carries the control bundle
// through the EX, MEM and WB stage registers. Lane 0 is the oldest lane.
// Flow control: there is no valid/ready handshake. stall and flush only
// turn the EX load into a bubble. MEM and WB advance on every edge.
module pipe_ctrl_decode #(
    parameter int LANES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LANES-1:0]     id_valid,
    input  logic [6*LANES-1:0]   id_op,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [LANES-1:0]     br_taken,
    output logic [LANES-1:0]     ex_valid,
    output logic [LANES-1:0]     ex_regdst,
    output logic [LANES-1:0]     ex_alusrc,
    output logic [3*LANES-1:0]   ex_aluop,
    output logic [2*LANES-1:0]   ex_branch,
    output logic [LANES-1:0]     ex_extop,
    output logic [LANES-1:0]     ex_illegal,
    output logic [LANES-1:0]     mem_valid,
    output logic [LANES-1:0]     mem_memwrite,
    output logic [LANES-1:0]     mem_memread,
    output logic [LANES-1:0]     wb_valid,
    output logic [LANES-1:0]     wb_regwrite,
    output logic [LANES-1:0]     wb_memtoreg
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;

    // Decoded ID bundle, already gated by id_valid
    logic [LANES-1:0]   dec_regdst;
    logic [LANES-1:0]   dec_alusrc;
    logic [3*LANES-1:0] dec_aluop;
    logic [2*LANES-1:0] dec_branch;
    logic [LANES-1:0]   dec_extop;
    logic [LANES-1:0]   dec_illegal;
    logic [LANES-1:0]   dec_memwrite;
    logic [LANES-1:0]   dec_memread;
    logic [LANES-1:0]   dec_regwrite;

    // Controls that are carried through EX but not exported there
    logic [LANES-1:0]   ex_memwrite_q;
    logic [LANES-1:0]   ex_memread_q;
    logic [LANES-1:0]   ex_regwrite_q;
    logic [LANES-1:0]   mem_regwrite_q;

    // Lanes allowed into MEM (cleared behind the oldest taken branch)
    logic [LANES-1:0]   mem_keep;

    // Per-lane opcode decode; an invalid lane decodes to all zeros
    always_comb begin
        logic [5:0] op;
        dec_regdst   = '0;
        dec_alusrc   = '0;
        dec_aluop    = '0;
        dec_branch   = '0;
        dec_extop    = '0;
        dec_illegal  = '0;
        dec_memwrite = '0;
        dec_memread  = '0;
        dec_regwrite = '0;
        op           = '0;
        for (int k = 0; k < LANES; k++) begin
            op = id_op[k*6 +: 6];
            if (id_valid[k]) begin
                case (op)
                    OP_RTYPE: begin
                        dec_regdst[k]       = 1'b1;
                        dec_regwrite[k]     = 1'b1;
                        dec_aluop[k*3 +: 3] = 3'b100;
                    end
                    OP_ADDI: begin
                        dec_alusrc[k]       = 1'b1;
                        dec_regwrite[k]     = 1'b1;
                    end
                    OP_LW: begin
                        dec_alusrc[k]       = 1'b1;
                        dec_memread[k]      = 1'b1;
                        dec_regwrite[k]     = 1'b1;
                        dec_extop[k]        = 1'b1;
                    end
                    OP_SW: begin
                        dec_alusrc[k]       = 1'b1;
                        dec_memwrite[k]     = 1'b1;
                        dec_extop[k]        = 1'b1;
                    end
                    OP_BEQ: begin
                        dec_branch[k*2 +: 2] = 2'b01;
                        dec_extop[k]         = 1'b1;
                        dec_aluop[k*3 +: 3]  = 3'b001;
                    end
                    OP_BNE: begin
                        dec_branch[k*2 +: 2] = 2'b10;
                        dec_extop[k]         = 1'b1;
                        dec_aluop[k*3 +: 3]  = 3'b001;
                    end
                    OP_BGTZ: begin
                        dec_branch[k*2 +: 2] = 2'b11;
                        dec_extop[k]         = 1'b1;
                    end
                    default: dec_illegal[k] = 1'b1;
                endcase
            end
        end
    end

    // Squash mask: a lane survives unless an older live lane took a branch
    always_comb begin
        logic seen;
        seen     = 1'b0;
        mem_keep = '0;
        for (int k = 0; k < LANES; k++) begin
            mem_keep[k] = ~seen;
            seen        = seen | (br_taken[k] & ex_valid[k]);
        end
    end

    // EX register: reset, then bubble on stall/flush, else load decode
    always_ff @(posedge clk) begin
        if (reset || stall || flush) begin
            ex_valid      <= '0;
            ex_regdst     <= '0;
            ex_alusrc     <= '0;
            ex_aluop      <= '0;
            ex_branch     <= '0;
            ex_extop      <= '0;
            ex_illegal    <= '0;
            ex_memwrite_q <= '0;
            ex_memread_q  <= '0;
            ex_regwrite_q <= '0;
        end else begin
            ex_valid      <= id_valid;
            ex_regdst     <= dec_regdst;
            ex_alusrc     <= dec_alusrc;
            ex_aluop      <= dec_aluop;
            ex_branch     <= dec_branch;
            ex_extop      <= dec_extop;
            ex_illegal    <= dec_illegal;
            ex_memwrite_q <= dec_memwrite;
            ex_memread_q  <= dec_memread;
            ex_regwrite_q <= dec_regwrite;
        end
    end

    // MEM register: always advances, younger lanes behind a taken branch die
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid      <= '0;
            mem_memwrite   <= '0;
            mem_memread    <= '0;
            mem_regwrite_q <= '0;
        end else begin
            mem_valid      <= ex_valid & mem_keep;
            mem_memwrite   <= ex_memwrite_q & mem_keep;
            mem_memread    <= ex_memread_q & mem_keep;
            mem_regwrite_q <= ex_regwrite_q & mem_keep;
        end
    end

    // WB register: copies MEM unchanged every edge
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid    <= '0;
            wb_regwrite <= '0;
            wb_memtoreg <= '0;
        end else begin
            wb_valid    <= mem_valid;
            wb_regwrite <= mem_regwrite_q;
            wb_memtoreg <= mem_memread;
        end
    end

endmodule
